// File: rtl/ptmch_spi_snoop_pkg.sv
// Shared types, opcode constants and opcode decode helpers for the SPI-NAND snooper.
// Latency: n/a (declarations only). Backpressure: n/a.
package ptmch_pkg;

    typedef enum logic [2:0] {WAIT_CS, IDLE, OPC, ADDR, DATA} snoop_st_t;

    localparam logic [7:0] OPC_PRGEXCT = 8'h10;
    localparam logic [7:0] OPC_RDSTAT  = 8'h0F;
    localparam logic [7:0] OPC_BLKERS  = 8'hD8;
    localparam logic [7:0] OPC_PDREAD  = 8'h13;
    localparam logic [7:0] OPC_WRSTAT  = 8'h1F;

    localparam int TRG_W = 5;

    // Trigger lane of an opcode; all zero for opcodes nobody listens to.
    function automatic logic [TRG_W-1:0] trg_map(input logic [7:0] opc);
        logic [TRG_W-1:0] m;
        m = '0;
        case (opc)
            OPC_PRGEXCT: m[0] = 1'b1;
            OPC_RDSTAT:  m[1] = 1'b1;
            OPC_BLKERS:  m[2] = 1'b1;
            OPC_PDREAD:  m[3] = 1'b1;
            OPC_WRSTAT:  m[4] = 1'b1;
            default:     m = '0;
        endcase
        return m;
    endfunction

    function automatic logic is_addr_opc(input logic [7:0] opc);
        return (opc == OPC_PRGEXCT) || (opc == OPC_PDREAD) || (opc == OPC_BLKERS);
    endfunction

endpackage

// File: rtl/ptmch_spi_snoop_if.sv
// Snooped SPI bus: the flash controller side drives it, the snooper only samples it.
// Latency: n/a (wires). Backpressure: none, the bus cannot be stalled.
interface ptmch_spi_snoop_if;
    logic SPI_SCLK;
    logic SPI_CS_N;
    logic SPI_MOSI;

    modport master (output SPI_SCLK, output SPI_CS_N, output SPI_MOSI);
    modport slave  (input  SPI_SCLK, input  SPI_CS_N, input  SPI_MOSI);
endinterface

// File: rtl/ptmch_spi_snoop_pls_stretch.sv
// Stretches a 1-cycle request into a PLS_WIDTH-cycle pulse followed by a PLS_WIDTH-cycle low gap.
// Latency: 1 cycle REQ->PLS. Backpressure: one request queued while busy, further ones dropped.
module ptmch_pls_stretch #(
    parameter int PLS_WIDTH = 4
) (
    input  logic CLK100M,
    input  logic RESET,
    input  logic REQ,
    output logic PLS
);
    localparam logic [3:0] CNT_INIT = 4'(PLS_WIDTH - 1);

    logic [3:0] cnt;
    logic       gap;
    logic       pend;

    always_ff @(posedge CLK100M or posedge RESET) begin
        if (RESET) begin
            PLS  <= 1'b0;
            gap  <= 1'b0;
            pend <= 1'b0;
            cnt  <= '0;
        end else if (PLS) begin
            if (REQ) pend <= 1'b1;
            if (cnt == '0) begin
                PLS <= 1'b0;
                gap <= 1'b1;
                cnt <= CNT_INIT;
            end else begin
                cnt <= cnt - 4'd1;
            end
        end else if (gap) begin
            // Last gap cycle: a queued or fresh request relaunches with no extra idle cycle.
            if (cnt == '0) begin
                gap <= 1'b0;
                if (pend || REQ) begin
                    PLS  <= 1'b1;
                    pend <= 1'b0;
                    cnt  <= CNT_INIT;
                end
            end else begin
                cnt <= cnt - 4'd1;
                if (REQ) pend <= 1'b1;
            end
        end else if (REQ) begin
            PLS <= 1'b1;
            cnt <= CNT_INIT;
        end
    end
endmodule

// File: rtl/ptmch_spi_snoop.sv
// Passive SPI-NAND command snooper: per-opcode trigger pulses, optional page address capture (PTMCH_SNOOP_PADDR_EN).
// Latency: SYNC_STG+1 cycles from CS_N rise to outputs. Backpressure: none, bus is only observed.
module ptmch_spi_snoop
    import ptmch_pkg::*;
#(
    parameter int SYNC_STG  = 2,
    parameter int PLS_WIDTH = 4
) (
    input  logic              CLK100M,
    input  logic              RESET,
    ptmch_spi_snoop_if.slave  spi,
    output logic [TRG_W-1:0]  TRG_PLS,
    output logic [7:0]        OPC_LAST,
    output logic              FRM_ERR,
    output logic [15:0]       PAGE_ADDR,
    output logic              PAGE_VLD
);
    logic [SYNC_STG-1:0] sclk_sync, cs_sync, mosi_sync;
    logic sclk_s, cs_s, mosi_s, sclk_d, cs_d;
    logic sclk_rise, cs_rise, cs_fall;

    snoop_st_t  st;
    logic [4:0] bit_cnt, cnt_nx;
    logic [7:0] opc_sh, opc_nx;
    logic       opc_end, addr_end, frm_done, frm_err;
    logic [TRG_W-1:0] trg_req;

    // CS_N chain resets low so WAIT_CS only leaves once a real deasserted CS_N has propagated.
    always_ff @(posedge CLK100M or posedge RESET) begin
        if (RESET) begin
            sclk_sync <= '0;
            cs_sync   <= '0;
            mosi_sync <= '0;
            sclk_d    <= 1'b0;
            cs_d      <= 1'b0;
        end else begin
            sclk_sync <= {sclk_sync[SYNC_STG-2:0], spi.SPI_SCLK};
            cs_sync   <= {cs_sync[SYNC_STG-2:0],   spi.SPI_CS_N};
            mosi_sync <= {mosi_sync[SYNC_STG-2:0], spi.SPI_MOSI};
            sclk_d    <= sclk_s;
            cs_d      <= cs_s;
        end
    end

    assign sclk_s    = sclk_sync[SYNC_STG-1];
    assign cs_s      = cs_sync[SYNC_STG-1];
    assign mosi_s    = mosi_sync[SYNC_STG-1];
    assign sclk_rise = sclk_s & ~sclk_d;
    assign cs_rise   = cs_s & ~cs_d;
    assign cs_fall   = ~cs_s & cs_d;

    // Bit shifted in this cycle is accounted before a coincident CS_N rise is judged.
    always_comb begin
        cnt_nx   = bit_cnt + {4'd0, sclk_rise};
        opc_nx   = (st == OPC && sclk_rise) ? {opc_sh[6:0], mosi_s} : opc_sh;
        opc_end  = (st == OPC) && (cnt_nx == 5'd8);
        addr_end = (st == ADDR) && (cnt_nx == 5'd24);
        frm_done = cs_rise && ((st == DATA) || addr_end || (opc_end && !is_addr_opc(opc_nx)));
        frm_err  = cs_rise && (((st == OPC) && !(opc_end && !is_addr_opc(opc_nx))) ||
                               ((st == ADDR) && !addr_end));
        trg_req  = frm_done ? trg_map(opc_nx) : '0;
    end

    always_ff @(posedge CLK100M or posedge RESET) begin
        if (RESET) begin
            st       <= WAIT_CS;
            bit_cnt  <= '0;
            opc_sh   <= '0;
            OPC_LAST <= '0;
            FRM_ERR  <= 1'b0;
        end else begin
            FRM_ERR <= frm_err;
            if (frm_done) OPC_LAST <= opc_nx;
            if (cs_fall && st != WAIT_CS) begin
                st      <= OPC;
                bit_cnt <= '0;
            end else begin
                case (st)
                    WAIT_CS: if (cs_s) st <= IDLE;
                    OPC: begin
                        opc_sh  <= opc_nx;
                        bit_cnt <= cnt_nx;
                        if (cs_rise) begin
                            st <= IDLE;
                        end else if (opc_end) begin
                            st      <= is_addr_opc(opc_nx) ? ADDR : DATA;
                            bit_cnt <= '0;
                        end
                    end
                    ADDR: begin
                        bit_cnt <= cnt_nx;
                        if (cs_rise)       st <= IDLE;
                        else if (addr_end) st <= DATA;
                    end
                    DATA: if (cs_rise) st <= IDLE;
                    default: ;
                endcase
            end
        end
    end

`ifdef PTMCH_SNOOP_PADDR_EN
    // Dummy byte shifts straight through; only the last 16 address bits are kept.
    logic [15:0] addr_sh, addr_nx, page_addr_q;
    logic        page_vld_q;

    assign addr_nx = (st == ADDR && sclk_rise) ? {addr_sh[14:0], mosi_s} : addr_sh;

    always_ff @(posedge CLK100M or posedge RESET) begin
        if (RESET) begin
            addr_sh     <= '0;
            page_addr_q <= '0;
            page_vld_q  <= 1'b0;
        end else begin
            addr_sh    <= addr_nx;
            page_vld_q <= 1'b0;
            if (frm_done && is_addr_opc(opc_nx)) begin
                page_addr_q <= addr_nx;
                page_vld_q  <= 1'b1;
            end
        end
    end

    assign PAGE_ADDR = page_addr_q;
    assign PAGE_VLD  = page_vld_q;
`else
    assign PAGE_ADDR = 16'h0000;
    assign PAGE_VLD  = 1'b0;
`endif

    for (genvar b = 0; b < TRG_W; b++) begin : g_pls
        ptmch_pls_stretch #(.PLS_WIDTH(PLS_WIDTH)) u_pls (
            .CLK100M (CLK100M),
            .RESET   (RESET),
            .REQ     (trg_req[b]),
            .PLS     (TRG_PLS[b])
        );
    end
endmodule

// File: tb/tb_ptmch_spi_snoop.sv
// Bench for ptmch_spi_snoop: directed frames plus random frames against a frame-level model.
module tb_ptmch_spi_snoop;
    localparam int W  = 4;
    localparam int HP = 40;

    logic CLK100M = 1'b0;
    logic RESET   = 1'b1;
    always #5 CLK100M = ~CLK100M;

    ptmch_spi_snoop_if spi();
    logic [4:0]  TRG_PLS;
    logic [7:0]  OPC_LAST;
    logic        FRM_ERR;
    logic [15:0] PAGE_ADDR;
    logic        PAGE_VLD;
    logic        s_req = 1'b0;
    logic        s_pls;

    ptmch_spi_snoop #(.SYNC_STG(2), .PLS_WIDTH(W)) dut (
        .CLK100M   (CLK100M),
        .RESET     (RESET),
        .spi       (spi),
        .TRG_PLS   (TRG_PLS),
        .OPC_LAST  (OPC_LAST),
        .FRM_ERR   (FRM_ERR),
        .PAGE_ADDR (PAGE_ADDR),
        .PAGE_VLD  (PAGE_VLD)
    );

    ptmch_pls_stretch #(.PLS_WIDTH(W)) u_str (
        .CLK100M (CLK100M),
        .RESET   (RESET),
        .REQ     (s_req),
        .PLS     (s_pls)
    );

    int checks = 0;
    int errors = 0;

    // Waveform monitor: pulse counts, pulse widths, low gaps, event cycle stamps.
    int cyc = 0;
    int pcnt[5]     = '{default: 0};
    int bad_w[5]    = '{default: 0};
    int bad_g[5]    = '{default: 0};
    int hi_len[5]   = '{default: 0};
    int lo_len[5]   = '{default: 0};
    int rise_cyc[5] = '{default: 0};
    bit seen[5]     = '{default: 1'b0};
    int err_cnt = 0, vld_cnt = 0, opc_cyc = 0;
    logic [4:0] prev_trg = '0;
    logic [7:0] prev_opc = '0;
    int cs_rise_cyc = 0;

    always @(posedge CLK100M) cyc <= cyc + 1;

    always @(negedge CLK100M) begin
        prev_trg <= TRG_PLS;
        prev_opc <= OPC_LAST;
        if (OPC_LAST !== prev_opc) opc_cyc <= cyc;
        if (FRM_ERR === 1'b1)  err_cnt <= err_cnt + 1;
        if (PAGE_VLD === 1'b1) vld_cnt <= vld_cnt + 1;
        for (int b = 0; b < 5; b++) begin
            if (TRG_PLS[b] === 1'b1 && !prev_trg[b]) begin
                pcnt[b]     <= pcnt[b] + 1;
                rise_cyc[b] <= cyc;
                hi_len[b]   <= 1;
                if (seen[b] && lo_len[b] < W) bad_g[b] <= bad_g[b] + 1;
            end else if (TRG_PLS[b] === 1'b1) begin
                hi_len[b] <= hi_len[b] + 1;
            end else begin
                lo_len[b] <= prev_trg[b] ? 1 : lo_len[b] + 1;
                if (prev_trg[b]) begin
                    seen[b] <= 1'b1;
                    if (hi_len[b] != W) bad_w[b] <= bad_w[b] + 1;
                end
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cs_low();
        @(posedge CLK100M); #1;
        spi.SPI_CS_N = 1'b0;
        #(HP);
    endtask

    task automatic send_bits(input logic [31:0] d, input int n, input int start);
        for (int i = 0; i < n; i++) begin
            spi.SPI_MOSI = d[31 - start - i];
            #(HP); spi.SPI_SCLK = 1'b1;
            #(HP); spi.SPI_SCLK = 1'b0;
        end
    endtask

    task automatic cs_high();
        #(HP);
        @(posedge CLK100M); #1;
        spi.SPI_CS_N = 1'b1;
        cs_rise_cyc  = cyc;
    endtask

    // Frame-level reference: what a completed or truncated frame must leave behind.
    logic [7:0]  exp_opc = 8'h00;
    logic [15:0] exp_pa  = 16'h0000;
    bit paddr_en;

    task automatic run_frame(input string tag, input logic [31:0] d, input int n);
        int p0[5];
        int e0, v0;
        logic [7:0] opc;
        bit ok, adr;
        logic [4:0] exp_trg;
        logic [31:0] obs_p, exp_p;
        p0 = pcnt; e0 = err_cnt; v0 = vld_cnt;
        cs_low(); send_bits(d, n, 0); cs_high();
        repeat (3 * W + 10) @(posedge CLK100M);
        #1;
        opc = d[31:24];
        adr = (opc == 8'h10) || (opc == 8'h13) || (opc == 8'hD8);
        ok  = (n >= 8) && (!adr || n >= 32);
        exp_trg = '0;
        if (ok) begin
            exp_opc = opc;
            case (opc)
                8'h10: exp_trg[0] = 1'b1;
                8'h0F: exp_trg[1] = 1'b1;
                8'hD8: exp_trg[2] = 1'b1;
                8'h13: exp_trg[3] = 1'b1;
                8'h1F: exp_trg[4] = 1'b1;
                default: exp_trg = '0;
            endcase
            if (adr && paddr_en) exp_pa = d[15:0];
        end
        obs_p = '0; exp_p = '0;
        for (int b = 0; b < 5; b++) begin
            obs_p = obs_p | (32'(pcnt[b] - p0[b]) << (4 * b));
            exp_p = exp_p | (32'(exp_trg[b]) << (4 * b));
        end
        check({tag, " OPC_LAST"}, 32'(OPC_LAST), 32'(exp_opc));
        check({tag, " TRG_PLS pulses"}, obs_p, exp_p);
        check({tag, " FRM_ERR cycles"}, 32'(err_cnt - e0), ok ? 32'd0 : 32'd1);
        check({tag, " PAGE_VLD cycles"}, 32'(vld_cnt - v0), (ok && adr && paddr_en) ? 32'd1 : 32'd0);
        check({tag, " PAGE_ADDR"}, 32'(PAGE_ADDR), 32'(exp_pa));
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

    initial begin
        logic [23:0] obs_s, exp_s;
        int p0[5];
        int e0;
`ifdef PTMCH_SNOOP_PADDR_EN
        paddr_en = 1'b1;
`else
        paddr_en = 1'b0;
`endif
        spi.SPI_CS_N = 1'b1;
        spi.SPI_SCLK = 1'b0;
        spi.SPI_MOSI = 1'b0;
        repeat (5) @(posedge CLK100M);
        #1;
        check("reset TRG_PLS", 32'(TRG_PLS), 32'h0);
        check("reset OPC_LAST", 32'(OPC_LAST), 32'h0);
        check("reset FRM_ERR/PAGE_VLD", {30'h0, FRM_ERR, PAGE_VLD}, 32'h0);
        check("reset PAGE_ADDR", 32'(PAGE_ADDR), 32'h0);
        RESET = 1'b0;
        repeat (6) @(posedge CLK100M);

        // 1: RDSTAT with feature byte and one data byte
        run_frame("T1", 32'h0FC0_5A00, 24);
        check("T1 TRG latency", 32'(rise_cyc[1] - cs_rise_cyc), 32'd3);
        check("T1 OPC_LAST latency", 32'(opc_cyc - cs_rise_cyc), 32'd3);

        // 2: PDREAD with full address
        run_frame("T2", 32'h1300_012A, 32);

        // 3: BLKERS cut after 16 address bits
        run_frame("T3", 32'hD800_0100, 24);

        // 4: back-to-back requests into one stretcher, third one must be dropped
        for (int n = 0; n < 6 * W; n++) begin
            @(posedge CLK100M); #1;
            obs_s[n] = s_pls;
            exp_s[n] = ((n >= 1) && (n <= W)) || ((n >= 2 * W + 1) && (n <= 3 * W));
            s_req = (n == 0) || (n == 2) || (n == 3);
        end
        s_req = 1'b0;
        check("T4 stretch waveform", 32'(obs_s), 32'(exp_s));

        // 5: reset in the middle of a WRSTAT opcode byte
        p0 = pcnt; e0 = err_cnt;
        cs_low();
        send_bits(32'h1F00_0000, 4, 0);
        @(posedge CLK100M); #1;
        RESET = 1'b1;
        repeat (3) @(posedge CLK100M);
        #1;
        check("T5 OPC_LAST in reset", 32'(OPC_LAST), 32'h0);
        RESET = 1'b0;
        exp_opc = 8'h00;
        exp_pa  = 16'h0000;
        send_bits(32'h1F00_0000, 12, 4);
        cs_high();
        repeat (3 * W + 10) @(posedge CLK100M);
        #1;
        check("T5 no pulse after reset", 32'(pcnt[4] - p0[4]), 32'd0);
        check("T5 no FRM_ERR after reset", 32'(err_cnt - e0), 32'd0);
        check("T5 OPC_LAST after reset", 32'(OPC_LAST), 32'h0);
        run_frame("T5b", 32'h1F_A0_3C_00, 16);

        // 6: unmapped opcode
        run_frame("T6", 32'h9F12_3456, 16);

        // Random frames: mapped and unmapped opcodes, occasionally truncated.
        for (int i = 0; i < 14; i++) begin
            logic [7:0]  op;
            logic [31:0] d;
            int nb;
            case ($urandom_range(0, 6))
                0: op = 8'h10;
                1: op = 8'h0F;
                2: op = 8'hD8;
                3: op = 8'h13;
                4: op = 8'h1F;
                default: op = 8'($urandom);
            endcase
            d  = {op, 24'($urandom)};
            nb = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 31)) : 32;
            run_frame("RND", d, nb);
        end

        check("pulse width violations", 32'(bad_w[0] + bad_w[1] + bad_w[2] + bad_w[3] + bad_w[4]), 32'd0);
        check("pulse gap violations", 32'(bad_g[0] + bad_g[1] + bad_g[2] + bad_g[3] + bad_g[4]), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
